// File: rtl/sample_requester_if.sv
// Sample-strobe handshake and status bundle between a waveform producer and the sample requester.
// The slave modport is the requester; the master modport is its controller/producer side.
interface sample_requester_if #(
    parameter int N_FRAC = 7,
    parameter int DIV_W  = 8
);
    logic                     enable_i;
    logic [DIV_W-1:0]         period_i;
    logic                     clear_i;
    logic                     next_data_strobe_o;
    logic signed [N_FRAC:0]   data_i;
    logic                     data_valid_strobe_i;
    logic signed [N_FRAC:0]   sample_o;
    logic                     sample_valid_strobe_o;
    logic signed [N_FRAC:0]   peak_max_o;
    logic signed [N_FRAC:0]   peak_min_o;
    logic                     timeout_o;
    logic                     overrun_o;

    modport slave (
        input  enable_i, period_i, clear_i, data_i, data_valid_strobe_i,
        output next_data_strobe_o, sample_o, sample_valid_strobe_o,
               peak_max_o, peak_min_o, timeout_o, overrun_o
    );

    modport master (
        output enable_i, period_i, clear_i, data_i, data_valid_strobe_i,
        input  next_data_strobe_o, sample_o, sample_valid_strobe_o,
               peak_max_o, peak_min_o, timeout_o, overrun_o
    );
endinterface

// File: rtl/sample_requester.sv
// Paces one-cycle sample requests at period_i+1 clocks, captures the producer's answer,
// and tracks the last sample, running extrema and sticky timeout/overrun flags.
module sample_requester #(
    parameter int N_FRAC  = 7,
    parameter int DIV_W   = 8,
    parameter int TIMEOUT = 4
) (
    input logic             clk_i,
    input logic             rst_i,
    sample_requester_if.slave bus
);
    localparam int W = N_FRAC + 1;
    localparam logic signed [W-1:0] PEAK_MAX_RST = {1'b1, {N_FRAC{1'b0}}};
    localparam logic signed [W-1:0] PEAK_MIN_RST = {1'b0, {N_FRAC{1'b1}}};
    localparam logic [3:0]          TO_LAST      = 4'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA} state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  cnt;
    logic              tick;
    logic [3:0]        to_cnt;
    logic              capture, to_event, ovr_event, req_nxt;

    assign tick = bus.enable_i && (cnt == '0);

    // Period counter: held at the programmed value while disabled so enabling
    // always yields a full interval before the first tick.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            cnt <= bus.period_i;
        else if (!bus.enable_i || cnt == '0)
            cnt <= bus.period_i;
        else
            cnt <= cnt - DIV_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (tick) state_nxt = REQ;
            REQ:       state_nxt = WAIT_DATA;
            WAIT_DATA: if (bus.data_valid_strobe_i || to_cnt == TO_LAST) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // A strobe on the last allowed WAIT_DATA cycle still counts as a response.
    always_comb begin
        capture   = (state == WAIT_DATA) && bus.data_valid_strobe_i;
        to_event  = (state == WAIT_DATA) && !bus.data_valid_strobe_i && (to_cnt == TO_LAST);
        ovr_event = tick && (state != IDLE);
        req_nxt   = (state_nxt == REQ);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                  to_cnt <= '0;
        else if (state == REQ)       to_cnt <= '0;
        else if (state == WAIT_DATA) to_cnt <= to_cnt + 4'd1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bus.next_data_strobe_o    <= 1'b0;
            bus.sample_o              <= '0;
            bus.sample_valid_strobe_o <= 1'b0;
            bus.peak_max_o            <= PEAK_MAX_RST;
            bus.peak_min_o            <= PEAK_MIN_RST;
            bus.timeout_o             <= 1'b0;
            bus.overrun_o             <= 1'b0;
        end else begin
            bus.next_data_strobe_o    <= req_nxt;
            bus.sample_valid_strobe_o <= capture;
            if (capture) begin
                bus.sample_o <= bus.data_i;
                if (bus.clear_i) begin
                    bus.peak_max_o <= bus.data_i;
                    bus.peak_min_o <= bus.data_i;
                end else begin
                    if (bus.data_i > bus.peak_max_o) bus.peak_max_o <= bus.data_i;
                    if (bus.data_i < bus.peak_min_o) bus.peak_min_o <= bus.data_i;
                end
            end else if (bus.clear_i) begin
                bus.peak_max_o <= PEAK_MAX_RST;
                bus.peak_min_o <= PEAK_MIN_RST;
            end
            // Events beat a simultaneous clear.
            bus.timeout_o <= to_event  | (bus.timeout_o & ~bus.clear_i);
            bus.overrun_o <= ovr_event | (bus.overrun_o & ~bus.clear_i);
        end
    end
endmodule

// File: tb/tb_sample_requester.sv
// Directed bench for sample_requester: a scripted producer answers requests with a set
// latency from a value table; each task checks one behaviour against hand-derived cycles.
module tb_sample_requester;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    sample_requester_if #(.N_FRAC(7), .DIV_W(8)) bus ();

    sample_requester #(.N_FRAC(7), .DIV_W(8), .TIMEOUT(4)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // producer model controls
    logic              resp_on = 1'b0;
    int                resp_lat = 1;
    logic signed [7:0] resp_vals [0:7];
    logic              inj = 1'b0;
    logic signed [7:0] inj_data = '0;
    int                resp_idx = 0;
    int                pend = 0;

    always @(posedge clk) begin
        logic fire;
        #2;
        fire = 1'b0;
        if (!rst_n) begin
            pend     = 0;
            resp_idx = 0;
        end else begin
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) fire = 1'b1;
            end
            if (bus.next_data_strobe_o && resp_on) pend = resp_lat;
        end
        if (fire) begin
            bus.data_i = (resp_idx < 8) ? resp_vals[resp_idx] : 8'sd0;
            resp_idx   = resp_idx + 1;
            bus.data_valid_strobe_i = 1'b1;
        end else if (inj) begin
            bus.data_i = inj_data;
            bus.data_valid_strobe_i = 1'b1;
        end else begin
            bus.data_valid_strobe_i = 1'b0;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bus.next_data_strobe_o) begin n = k; break; end
        end
    endtask

    task automatic wait_cap(output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bus.sample_valid_strobe_o) begin n = k; break; end
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        bus.enable_i = 1'b0;
        bus.clear_i  = 1'b0;
        resp_on = 1'b0;
        inj     = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset;
        total++; if (bus.sample_o !== 8'sd0) begin bad++; $display("FAIL reset_sample got %0d want 0", bus.sample_o); end
        total++; if (bus.peak_max_o !== -8'sd128) begin bad++; $display("FAIL reset_peak_max got %0d want -128", bus.peak_max_o); end
        total++; if (bus.peak_min_o !== 8'sd127) begin bad++; $display("FAIL reset_peak_min got %0d want 127", bus.peak_min_o); end
        total++;
        if ({bus.next_data_strobe_o, bus.sample_valid_strobe_o, bus.timeout_o, bus.overrun_o} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got %b want 0000",
                {bus.next_data_strobe_o, bus.sample_valid_strobe_o, bus.timeout_o, bus.overrun_o});
        end
    endtask

    task automatic test_basic;
        int n;
        logic signed [7:0] exp_s [0:2];
        exp_s[0] = 8'sd5; exp_s[1] = 8'sd6; exp_s[2] = 8'sd7;
        bus.period_i = 8'd3;
        do_reset();
        resp_vals[0] = 8'sd5; resp_vals[1] = 8'sd6; resp_vals[2] = 8'sd7;
        resp_lat = 1; resp_on = 1'b1;
        bus.enable_i = 1'b1;
        wait_req(n);
        total++; if (n !== 4) begin bad++; $display("FAIL basic_first_req got %0d want 4", n); end
        for (int i = 1; i <= 10; i++) begin
            step();
            total++;
            if (bus.next_data_strobe_o !== (i % 4 == 0)) begin
                bad++; $display("FAIL basic_req_pace i=%0d got %b want %b", i, bus.next_data_strobe_o, (i % 4 == 0));
            end
            total++;
            if (bus.sample_valid_strobe_o !== (i % 4 == 2)) begin
                bad++; $display("FAIL basic_valid_pace i=%0d got %b want %b", i, bus.sample_valid_strobe_o, (i % 4 == 2));
            end
            if (i % 4 == 2) begin
                total++;
                if (bus.sample_o !== exp_s[i/4]) begin
                    bad++; $display("FAIL basic_sample i=%0d got %0d want %0d", i, bus.sample_o, exp_s[i/4]);
                end
            end
        end
        bus.enable_i = 1'b0;
        total++; if (bus.peak_max_o !== 8'sd7 || bus.peak_min_o !== 8'sd5) begin
            bad++; $display("FAIL basic_peaks got %0d/%0d want 7/5", bus.peak_max_o, bus.peak_min_o); end
        total++; if (bus.timeout_o !== 1'b0 || bus.overrun_o !== 1'b0) begin
            bad++; $display("FAIL basic_flags got %b%b want 00", bus.timeout_o, bus.overrun_o); end
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_peaks_clear;
        int n;
        bus.period_i = 8'd3;
        do_reset();
        resp_vals[0] = -8'sd100; resp_vals[1] = 8'sd20; resp_vals[2] = 8'sd90;
        resp_vals[3] = 8'sd3;    resp_vals[4] = -8'sd7;
        resp_lat = 1; resp_on = 1'b1;
        bus.enable_i = 1'b1;
        for (int k = 0; k < 3; k++) wait_cap(n);
        total++; if (n < 0) begin bad++; $display("FAIL peaks_wait got timeout want capture"); end
        total++; if (bus.peak_max_o !== 8'sd90 || bus.peak_min_o !== -8'sd100) begin
            bad++; $display("FAIL peaks_before_clear got %0d/%0d want 90/-100", bus.peak_max_o, bus.peak_min_o); end
        bus.clear_i = 1'b1;
        step();
        bus.clear_i = 1'b0;
        total++; if (bus.peak_max_o !== -8'sd128 || bus.peak_min_o !== 8'sd127) begin
            bad++; $display("FAIL peaks_after_clear got %0d/%0d want -128/127", bus.peak_max_o, bus.peak_min_o); end
        wait_cap(n);
        total++; if (bus.sample_o !== 8'sd3 || bus.peak_max_o !== 8'sd3 || bus.peak_min_o !== 8'sd3) begin
            bad++; $display("FAIL peaks_first_after_clear got s=%0d %0d/%0d want 3 3/3",
                bus.sample_o, bus.peak_max_o, bus.peak_min_o); end
        wait_req(n);
        step();
        bus.clear_i = 1'b1;
        step();
        bus.clear_i = 1'b0;
        bus.enable_i = 1'b0;
        total++; if (bus.sample_valid_strobe_o !== 1'b1 || bus.peak_max_o !== -8'sd7 || bus.peak_min_o !== -8'sd7) begin
            bad++; $display("FAIL peaks_clear_with_capture got v=%b %0d/%0d want 1 -7/-7",
                bus.sample_valid_strobe_o, bus.peak_max_o, bus.peak_min_o); end
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_timeout;
        int n;
        bus.period_i = 8'd7;
        do_reset();
        resp_vals[0] = 8'sd42;
        resp_lat = 1; resp_on = 1'b1;
        bus.enable_i = 1'b1;
        wait_cap(n);
        total++; if (bus.sample_o !== 8'sd42) begin bad++; $display("FAIL to_first_sample got %0d want 42", bus.sample_o); end
        resp_on = 1'b0;
        wait_req(n);
        total++; if (n !== 6) begin bad++; $display("FAIL to_req_spacing got %0d want 6", n); end
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 7) inj = 1'b0;
            total++;
            if (bus.timeout_o !== (i >= 5)) begin
                bad++; $display("FAIL to_flag i=%0d got %b want %b", i, bus.timeout_o, (i >= 5)); end
            total++;
            if (bus.next_data_strobe_o !== (i == 8)) begin
                bad++; $display("FAIL to_next_req i=%0d got %b want %b", i, bus.next_data_strobe_o, (i == 8)); end
            total++;
            if (bus.sample_o !== 8'sd42 || bus.sample_valid_strobe_o !== 1'b0) begin
                bad++; $display("FAIL to_sample_hold i=%0d got %0d v=%b want 42 v=0", i, bus.sample_o, bus.sample_valid_strobe_o); end
            if (i == 6) begin inj_data = 8'sd99; inj = 1'b1; end
        end
        bus.enable_i = 1'b0;
        total++; if (bus.peak_max_o !== 8'sd42 || bus.peak_min_o !== 8'sd42 || bus.overrun_o !== 1'b0) begin
            bad++; $display("FAIL to_peaks got %0d/%0d ovr=%b want 42/42 ovr=0", bus.peak_max_o, bus.peak_min_o, bus.overrun_o); end
        for (int i = 0; i < 8; i++) step();
    endtask

    task automatic test_overrun;
        int n;
        logic signed [7:0] exp_s [0:2];
        exp_s[0] = 8'sd11; exp_s[1] = 8'sd22; exp_s[2] = 8'sd33;
        bus.period_i = 8'd1;
        do_reset();
        resp_vals[0] = 8'sd11; resp_vals[1] = 8'sd22; resp_vals[2] = 8'sd33;
        resp_lat = 3; resp_on = 1'b1;
        bus.enable_i = 1'b1;
        wait_req(n);
        total++; if (bus.overrun_o !== 1'b0) begin bad++; $display("FAIL ovr_early got %b want 0", bus.overrun_o); end
        for (int k = 0; k < 3; k++) begin
            wait_cap(n);
            total++;
            if (n < 0 || bus.sample_o !== exp_s[k]) begin
                bad++; $display("FAIL ovr_capture k=%0d got %0d want %0d", k, bus.sample_o, exp_s[k]); end
            total++;
            if (bus.overrun_o !== 1'b1 || bus.timeout_o !== 1'b0) begin
                bad++; $display("FAIL ovr_flags k=%0d got ovr=%b to=%b want 1 0", k, bus.overrun_o, bus.timeout_o); end
        end
        bus.enable_i = 1'b0;
        for (int i = 0; i < 8; i++) step();
    endtask

    task automatic test_enable_edge;
        int n;
        int stray;
        bus.period_i = 8'd3;
        do_reset();
        resp_vals[0] = 8'sd55;
        resp_lat = 1; resp_on = 1'b1;
        bus.enable_i = 1'b1;
        wait_req(n);
        bus.enable_i = 1'b0;
        step();
        step();
        total++; if (bus.sample_valid_strobe_o !== 1'b1 || bus.sample_o !== 8'sd55) begin
            bad++; $display("FAIL en_capture got v=%b s=%0d want 1 55", bus.sample_valid_strobe_o, bus.sample_o); end
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.next_data_strobe_o) stray++;
        end
        total++; if (stray !== 0) begin bad++; $display("FAIL en_no_more_req got %0d want 0", stray); end
    endtask

    task automatic test_reset_mid;
        int n;
        int stray;
        bus.period_i = 8'd3;
        do_reset();
        resp_vals[0] = 8'sd77;
        resp_lat = 1; resp_on = 1'b1;
        bus.enable_i = 1'b1;
        wait_cap(n);
        total++; if (bus.sample_o !== 8'sd77) begin bad++; $display("FAIL rst_pre_sample got %0d want 77", bus.sample_o); end
        resp_on = 1'b0;
        wait_req(n);
        step();
        rst_n = 1'b0;
        #1;
        total++; if (bus.sample_o !== 8'sd0 || bus.peak_max_o !== -8'sd128 || bus.peak_min_o !== 8'sd127) begin
            bad++; $display("FAIL rst_async got s=%0d %0d/%0d want 0 -128/127", bus.sample_o, bus.peak_max_o, bus.peak_min_o); end
        step();
        rst_n = 1'b1;
        inj_data = 8'sd66; inj = 1'b1;
        step();
        inj = 1'b0;
        total++; if (bus.sample_o !== 8'sd0 || bus.sample_valid_strobe_o !== 1'b0) begin
            bad++; $display("FAIL rst_late_strobe got s=%0d v=%b want 0 0", bus.sample_o, bus.sample_valid_strobe_o); end
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.sample_valid_strobe_o) stray++;
        end
        bus.enable_i = 1'b0;
        total++; if (stray !== 0 || bus.sample_o !== 8'sd0) begin
            bad++; $display("FAIL rst_after got valids=%0d s=%0d want 0 0", stray, bus.sample_o); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.enable_i = 1'b0;
        bus.clear_i  = 1'b0;
        bus.period_i = 8'd3;
        for (int i = 0; i < 8; i++) resp_vals[i] = '0;
        step();
        step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_basic();
        test_peaks_clear();
        test_timeout();
        test_overrun();
        test_enable_edge();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
